param_seq_datapath: RTL

- Parametrised, sequenced successor of the team's 8-bit four-register datapath.
- Generalises data width and register count.
- Adds a valid/ready command interface and a multi-cycle micro-sequencer (read → execute → writeback) with status flags and a completion pulse.
- Sits between a host controller issuing register-level commands and downstream logic that consumes R0 on out.

---
 rtl/param_seq_datapath_pkg.sv | 26 ++
 rtl/seq_dp_alu.sv | 35 +++
 rtl/param_seq_datapath.sv | 111 +++++++++++
 3 files changed

// File: rtl/param_seq_datapath_pkg.sv
// param_seq_datapath_pkg: opcodes and FSM states shared by the sequenced datapath
package param_seq_datapath_pkg;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [2:0] {
        LOAD = OP_LOAD,
        MOV  = OP_MOV,
        XOR  = OP_XOR,
        AND  = OP_AND,
        SHL  = OP_SHL,
        ADD  = OP_ADD,
        NOT  = OP_NOT,
        NOP  = OP_NOP
    } op_t;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

endpackage

// File: rtl/seq_dp_alu.sv
// seq_dp_alu: combinational operation decode producing result and carry-out
module seq_dp_alu
    import param_seq_datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] res,
    output logic             carry_out
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    // Select the result; only SHL and ADD produce a carry, NOP yields a don't-care zero
    always_comb begin
        res       = '0;
        carry_out = 1'b0;
        case (op)
            LOAD: res = imm;
            MOV:  res = b;
            XOR:  res = a ^ b;
            AND:  res = a & b;
            SHL:  {carry_out, res} = {a, 1'b0};
            ADD:  {carry_out, res} = sum;
            NOT:  res = ~a;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/param_seq_datapath.sv
// param_seq_datapath: register file with valid/ready commands run as read/execute/writeback
module param_seq_datapath
    import param_seq_datapath_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [RAW-1:0]   cmd_rd,
    input  logic [RAW-1:0]   cmd_rs,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             busy,
    output logic             done,
    output logic             zero,
    output logic             carry,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 2 || NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_params
        $error("param_seq_datapath: WIDTH must be >= 2 and NREGS a power of two >= 2");
    end

    state_t           state_q, state_d;
    op_t              op_q;
    logic [RAW-1:0]   rd_q, rs_q;
    logic [WIDTH-1:0] imm_q, tmp_q, b_q, res_q;
    logic             cnext_q, zero_q, carry_q, done_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             accept;

    assign accept    = cmd_valid && state_q == IDLE;
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign out       = regs_q[0];

    seq_dp_alu #(.WIDTH(WIDTH)) u_alu (
        .op        (op_q),
        .a         (tmp_q),
        .b         (b_q),
        .imm       (imm_q),
        .res       (alu_res),
        .carry_out (alu_carry)
    );

    // Sequencer: each accepted command walks READ, EXEC, WB and returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath: capture command, read operands, execute, write back and publish flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= NOP;
            rd_q    <= '0;
            rs_q    <= '0;
            imm_q   <= '0;
            tmp_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnext_q <= 1'b0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            done_q <= state_q == WB;
            if (accept) begin
                op_q  <= op_t'(cmd_op);
                rd_q  <= cmd_rd;
                rs_q  <= cmd_rs;
                imm_q <= cmd_imm;
            end
            if (state_q == READ) begin
                tmp_q <= regs_q[rd_q];
                b_q   <= regs_q[rs_q];
            end
            if (state_q == EXEC) begin
                res_q   <= alu_res;
                cnext_q <= alu_carry;
            end
            if (state_q == WB && op_q != NOP) begin
                regs_q[rd_q] <= res_q;
                zero_q       <= res_q == '0;
                carry_q      <= cnext_q;
            end
        end
    end

endmodule
